// File: rtl/sf_fft_pkg.sv
// rtl/sf_fft_pkg.sv - shared widths and averager state encoding
package sf_fft_pkg;
  localparam int PH_WIDTH   = 32;
  localparam int MAG_WIDTH  = 32;
  localparam int FCNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FINISH = 2'd2
  } avg_state_t;
endpackage

// File: rtl/result_averager_if.sv
// rtl/result_averager_if.sv - sample input and block-average output bundle
interface result_averager_if;
  import sf_fft_pkg::*;

  logic                         i_vld;
  logic signed [PH_WIDTH-1:0]   delta_ph;
  logic        [MAG_WIDTH-1:0]  div_mag;
  logic                         clr;
  logic signed [PH_WIDTH-1:0]   avg_ph;
  logic        [MAG_WIDTH-1:0]  avg_mag;
  logic                         o_vld;
  logic        [FCNT_WIDTH-1:0] frame_cnt;

  modport master (
    output i_vld, delta_ph, div_mag, clr,
    input  avg_ph, avg_mag, o_vld, frame_cnt
  );

  modport slave (
    input  i_vld, delta_ph, div_mag, clr,
    output avg_ph, avg_mag, o_vld, frame_cnt
  );
endinterface

// File: rtl/result_averager.sv
// rtl/result_averager.sv - block mean of N = 2^LOG2_NAVG phase/magnitude frames
module result_averager
  import sf_fft_pkg::*;
#(
  parameter int LOG2_NAVG = 2
) (
  input  logic              clk,
  input  logic              rstn,
  result_averager_if.slave  bus
);

  localparam int AW = PH_WIDTH + LOG2_NAVG;
  localparam int CW = LOG2_NAVG + 1;
  localparam logic [CW-1:0] N_CNT = CW'(1) << LOG2_NAVG;

  avg_state_t                  state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d, cnt_inc;
  logic [PH_WIDTH-1:0]         ref_q, ref_d;
  logic signed [AW-1:0]        sum_dev_q, sum_dev_d;
  logic [AW-1:0]               sum_mag_q, sum_mag_d;
  logic [PH_WIDTH-1:0]         avg_ph_q, avg_ph_d;
  logic [MAG_WIDTH-1:0]        avg_mag_q, avg_mag_d;
  logic                        o_vld_q, o_vld_d;
  logic [FCNT_WIDTH-1:0]       frame_cnt_q, frame_cnt_d;
  logic signed [PH_WIDTH-1:0]  dev;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ref_d       = ref_q;
    sum_dev_d   = sum_dev_q;
    sum_mag_d   = sum_mag_q;
    avg_ph_d    = avg_ph_q;
    avg_mag_d   = avg_mag_q;
    o_vld_d     = 1'b0;
    frame_cnt_d = frame_cnt_q;
    cnt_inc     = cnt_q + CW'(1);
    // Deviation from the block reference is taken modulo 2^32, so wrap at +/-pi is harmless.
    dev         = bus.delta_ph - ref_q;

    if (state_q == FINISH) begin
      avg_ph_d    = ref_q + PH_WIDTH'(sum_dev_q >>> LOG2_NAVG);
      avg_mag_d   = MAG_WIDTH'(sum_mag_q >> LOG2_NAVG);
      o_vld_d     = 1'b1;
      frame_cnt_d = frame_cnt_q + FCNT_WIDTH'(1);
      state_d     = IDLE;
      cnt_d       = '0;
    end else if (state_q != ACCUM) begin
      state_d = IDLE;
    end

    if (bus.clr) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (bus.i_vld) begin
      if (state_q == ACCUM) begin
        sum_dev_d = sum_dev_q + AW'(dev);
        sum_mag_d = sum_mag_q + AW'(bus.div_mag);
        cnt_d     = cnt_inc;
        state_d   = (cnt_inc == N_CNT) ? FINISH : ACCUM;
      end else begin
        // FINISH behaves like IDLE here so back-to-back frames start the next block.
        ref_d     = bus.delta_ph;
        sum_dev_d = '0;
        sum_mag_d = AW'(bus.div_mag);
        cnt_d     = CW'(1);
        state_d   = (N_CNT == CW'(1)) ? FINISH : ACCUM;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ref_q       <= '0;
      sum_dev_q   <= '0;
      sum_mag_q   <= '0;
      avg_ph_q    <= '0;
      avg_mag_q   <= '0;
      o_vld_q     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ref_q       <= ref_d;
      sum_dev_q   <= sum_dev_d;
      sum_mag_q   <= sum_mag_d;
      avg_ph_q    <= avg_ph_d;
      avg_mag_q   <= avg_mag_d;
      o_vld_q     <= o_vld_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.avg_ph    = avg_ph_q;
  assign bus.avg_mag   = avg_mag_q;
  assign bus.o_vld     = o_vld_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: doc/result_averager.md
RESULT_AVERAGER -- requirements
Module: result_averager

Interface
REQ-001 Parameter LOG2_NAVG, default 2: block length N = 2^LOG2_NAVG frames; legal range 0..8.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 rstn  input  1  asynchronous, active-low reset.
REQ-004 i_vld  input  1  one-cycle strobe: delta_ph/div_mag valid (o_vld of the upstream computing cascade).
REQ-005 delta_ph  input  32 signed  phase difference, binary-angle format (2^32 = 2*pi, modular).
REQ-006 div_mag  input  32 unsigned  magnitude ratio.
REQ-007 clr  input  1  synchronous block abort; discards the partial block.
REQ-008 avg_ph  output  32 signed  block-mean phase, binary-angle format.
REQ-009 avg_mag  output  32 unsigned  block-mean magnitude ratio.
REQ-010 o_vld  output  1  one-cycle strobe: avg_ph/avg_mag/frame_cnt updated.
REQ-011 frame_cnt  output  16  number of completed blocks, wraps 0xFFFF->0x0000.

Function
REQ-012 FSM states: IDLE (no samples held), ACCUM (1..N-1 samples held), FINISH (N samples held, one cycle only).
REQ-013 IDLE + i_vld: ref <= delta_ph, sum_dev <= 0, sum_mag <= div_mag, cnt <= 1; go to ACCUM, or to FINISH when N = 1.
REQ-014 ACCUM + i_vld: sum_dev += signed 32-bit modular (delta_ph - ref), sign-extended to 32+LOG2_NAVG bits; sum_mag += div_mag, zero-extended to 32+LOG2_NAVG bits; cnt += 1; go to FINISH when cnt reaches N.
REQ-015 ACCUM without i_vld: hold all state, no timeout.
REQ-016 FINISH: avg_ph <= ref + (sum_dev >>> LOG2_NAVG) truncated to 32 bits (modulo 2^32); avg_mag <= sum_mag >> LOG2_NAVG; o_vld = 1 for exactly that cycle; frame_cnt += 1.
REQ-017 Rounding: arithmetic shift (floor) for the phase sum, logical shift for the magnitude sum; no rounding constant.
REQ-018 Latency: N-th sample sampled at edge E; outputs and o_vld change at edge E+1; o_vld deasserts at edge E+2.
REQ-019 i_vld during FINISH: treated as IDLE + i_vld (first sample of the next block); no sample lost; back-to-back i_vld sustained indefinitely.
REQ-020 clr = 1 in IDLE or ACCUM: go to IDLE, cnt <= 0; the concurrent i_vld sample is discarded; outputs and frame_cnt are unchanged.
REQ-021 clr = 1 in FINISH: the completing output is still produced; the next state is IDLE and a concurrent i_vld is discarded.
REQ-022 avg_ph, avg_mag and frame_cnt hold their values between o_vld pulses.
REQ-023 No internal overflow: accumulator width 32+LOG2_NAVG is exact for N samples.

Reset
REQ-024 rstn low: asynchronously force state IDLE; cnt, ref, sum_dev, sum_mag, avg_ph, avg_mag, frame_cnt = 0; o_vld = 0.
REQ-025 Reset mid-block discards the partial block; no o_vld for it after release.
REQ-026 First i_vld accepted on the first rising edge with rstn high.

Structure
REQ-027 Shared package sf_fft_pkg holds PH_WIDTH = 32, MAG_WIDTH = 32, FCNT_WIDTH = 16 and the avg_state_t enum (IDLE, ACCUM, FINISH); the upstream cascade's output widths reference the same constants.
REQ-028 Single flat module; no sub-module. The phase and magnitude accumulators are inline register pairs.

Verification (LOG2_NAVG = 2 unless stated)
REQ-029 Constant input, spaced 9 clk: 4 x (delta_ph = 0x10000000, div_mag = 0x00010000) -> one o_vld, 1 clk after the 4th sampling edge; avg_ph = 0x10000000, avg_mag = 0x00010000, frame_cnt = 1.
REQ-030 Wrap: delta_ph = 0x7FFFFFF0, 0x80000010, 0x7FFFFFF0, 0x80000010 and div_mag = 1, 2, 3, 4 -> avg_ph = 0x80000000, avg_mag = 2.
REQ-031 Negative deviation: delta_ph = 0, 0xFFFFFFFC, 0xFFFFFFFC, 0xFFFFFFFC -> avg_ph = 0xFFFFFFFD (floor of -3).
REQ-032 Back-to-back: i_vld high for 8 consecutive cycles -> two o_vld pulses 4 clk apart; frame_cnt = 1 then 2.
REQ-033 Abort and reset: 2 samples, then clr; 4 samples of 0x20000000 -> single o_vld with avg_ph = 0x20000000. Then 3 samples, rstn low for 2 clk -> all outputs 0; the next 4 samples give a correct average with frame_cnt = 1.
